// File: rtl/axi_ar_rr_arbiter_pkg.sv
// Shared types and constants for the AXI read-channel arbiter slice.
// ar_fields_t is sized for the widest supported configuration; users keep the low bits.
package axi_arb_pkg;

  localparam int AXI_ID_MAX   = 16;
  localparam int AXI_ADDR_MAX = 64;
  localparam int AXI_USER_MAX = 32;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [2:0] AXI_SIZE_4B   = 3'd2;
  localparam logic [2:0] AXI_SIZE_64B  = 3'd6;
  localparam logic [2:0] AXI_SIZE_128B = 3'd7;

  typedef struct packed {
    logic [AXI_ID_MAX-1:0]   id;
    logic [AXI_ADDR_MAX-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic [AXI_USER_MAX-1:0] user;
  } ar_fields_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/axi_ar_rr_arbiter_if.sv
// Bus bundle between NUM_REQ read engines, the arbiter and the host AR/R port.
// Handshake: a transfer happens in any cycle where valid and ready are both high; valid never waits on ready.
interface axi_ar_rr_arbiter_if
  import axi_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int REQ_ID_WIDTH = 3,
  parameter int ADDR_WIDTH   = 64,
  parameter int DATA_WIDTH   = 1024,
  parameter int ARUSER_WIDTH = 8
);
  localparam int IDX_WIDTH = clog2(NUM_REQ);
  localparam int ID_WIDTH  = IDX_WIDTH + REQ_ID_WIDTH;

  logic [NUM_REQ-1:0]              s_arvalid;
  logic [NUM_REQ-1:0]              s_arready;
  logic [NUM_REQ*REQ_ID_WIDTH-1:0] s_arid;
  logic [NUM_REQ*ADDR_WIDTH-1:0]   s_araddr;
  logic [NUM_REQ*8-1:0]            s_arlen;
  logic [NUM_REQ*3-1:0]            s_arsize;
  logic [NUM_REQ*2-1:0]            s_arburst;
  logic [NUM_REQ*ARUSER_WIDTH-1:0] s_aruser;
  logic [NUM_REQ-1:0]              s_rvalid;
  logic [NUM_REQ-1:0]              s_rready;
  logic [REQ_ID_WIDTH-1:0]         s_rid;
  logic [DATA_WIDTH-1:0]           s_rdata;
  logic [1:0]                      s_rresp;
  logic                            s_rlast;

  logic                    m_arvalid;
  logic                    m_arready;
  logic [ID_WIDTH-1:0]     m_arid;
  logic [ADDR_WIDTH-1:0]   m_araddr;
  logic [7:0]              m_arlen;
  logic [2:0]              m_arsize;
  logic [1:0]              m_arburst;
  logic [ARUSER_WIDTH-1:0] m_aruser;
  logic                    m_rvalid;
  logic                    m_rready;
  logic [ID_WIDTH-1:0]     m_rid;
  logic [DATA_WIDTH-1:0]   m_rdata;
  logic [1:0]              m_rresp;
  logic                    m_rlast;

  // slave: the arbiter itself. master: the engines plus the host port around it.
  modport slave (
    input  s_arvalid, s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_aruser, s_rready,
    output s_arready, s_rvalid, s_rid, s_rdata, s_rresp, s_rlast,
    output m_arvalid, m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_aruser, m_rready,
    input  m_arready, m_rvalid, m_rid, m_rdata, m_rresp, m_rlast
  );

  modport master (
    output s_arvalid, s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_aruser, s_rready,
    input  s_arready, s_rvalid, s_rid, s_rdata, s_rresp, s_rlast,
    input  m_arvalid, m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_aruser, m_rready,
    output m_arready, m_rvalid, m_rid, m_rdata, m_rresp, m_rlast
  );

endinterface

// File: rtl/axi_ar_rr_arbiter_rr_pick.sv
// Rotating-priority encoder: first asserted req at or after ptr, wrapping at NUM_REQ.
// Purely combinational so the AW-channel arbiter can share it.
module rr_pick #(
  parameter int NUM_REQ   = 4,
  parameter int IDX_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]   grant,
  output logic [IDX_WIDTH-1:0] grant_idx,
  output logic                 any
);

  always_comb begin
    int j;
    j         = 0;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!any && req[j]) begin
        any       = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IDX_WIDTH'(j);
      end
    end
  end

endmodule

// File: rtl/axi_ar_rr_arbiter.sv
// Round-robin share of one host AXI read channel among NUM_REQ engines: AR register,
// per-requester outstanding-burst counters and an RID-indexed R demux.
module axi_ar_rr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int REQ_ID_WIDTH    = 3,
  parameter int ADDR_WIDTH      = 64,
  parameter int DATA_WIDTH      = 1024,
  parameter int ARUSER_WIDTH    = 8,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  axi_ar_rr_arbiter_if.slave    bus,
  output logic [7:0]            outstanding_tot,
  output logic                  idle,
  output logic                  rid_err
);

  localparam int IDX_WIDTH = clog2(NUM_REQ);
  localparam int ID_WIDTH  = IDX_WIDTH + REQ_ID_WIDTH;
  localparam int CNT_W     = clog2(MAX_OUTSTANDING + 1);

  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   grant;
  logic [IDX_WIDTH-1:0] grant_idx;
  logic [IDX_WIDTH-1:0] ptr;
  logic                 any;
  logic                 load;
  logic                 arvalid_q;
  logic                 arvalid_nxt;
  ar_fields_t           ar_q;
  ar_fields_t           ar_sel;
  logic [CNT_W-1:0]     cnt     [NUM_REQ];
  logic [CNT_W-1:0]     cnt_nxt [NUM_REQ];
  logic [7:0]           tot_nxt;
  logic                 all_zero;
  logic [IDX_WIDTH-1:0] r_idx;
  logic                 r_ok;
  logic                 r_last_hs;
  logic                 unused_ar_bits;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      eligible[i] = bus.s_arvalid[i] && (cnt[i] < CNT_W'(MAX_OUTSTANDING));
  end

  rr_pick #(
    .NUM_REQ   (NUM_REQ),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_pick (
    .req       (eligible),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  assign load          = (!arvalid_q || bus.m_arready) && any;
  assign bus.s_arready = load ? grant : '0;
  assign arvalid_nxt   = load || (arvalid_q && !bus.m_arready);

  always_comb begin
    ar_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        ar_sel.id    = AXI_ID_MAX'({IDX_WIDTH'(i), bus.s_arid[i*REQ_ID_WIDTH +: REQ_ID_WIDTH]});
        ar_sel.addr  = AXI_ADDR_MAX'(bus.s_araddr[i*ADDR_WIDTH +: ADDR_WIDTH]);
        ar_sel.len   = bus.s_arlen[i*8 +: 8];
        ar_sel.size  = bus.s_arsize[i*3 +: 3];
        ar_sel.burst = bus.s_arburst[i*2 +: 2];
        ar_sel.user  = AXI_USER_MAX'(bus.s_aruser[i*ARUSER_WIDTH +: ARUSER_WIDTH]);
      end
    end
  end

  assign bus.m_arvalid = arvalid_q;
  assign bus.m_arid    = ar_q.id[ID_WIDTH-1:0];
  assign bus.m_araddr  = ar_q.addr[ADDR_WIDTH-1:0];
  assign bus.m_arlen   = ar_q.len;
  assign bus.m_arsize  = ar_q.size;
  assign bus.m_arburst = ar_q.burst;
  assign bus.m_aruser  = ar_q.user[ARUSER_WIDTH-1:0];
  // Upper bits of the max-width field struct carry no information.
  assign unused_ar_bits = ^ar_q;

  // R demux: indices past NUM_REQ have no owner, so the beat is swallowed.
  assign r_idx = bus.m_rid[ID_WIDTH-1 -: IDX_WIDTH];
  assign r_ok  = int'(r_idx) < NUM_REQ;

  always_comb begin
    bus.s_rvalid = '0;
    bus.m_rready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (int'(r_idx) == i) begin
        bus.s_rvalid[i] = bus.m_rvalid;
        bus.m_rready    = bus.s_rready[i];
      end
    end
  end

  assign bus.s_rid   = bus.m_rid[REQ_ID_WIDTH-1:0];
  assign bus.s_rdata = bus.m_rdata;
  assign bus.s_rresp = bus.m_rresp;
  assign bus.s_rlast = bus.m_rlast;
  assign r_last_hs   = bus.m_rvalid && bus.m_rready && bus.m_rlast && r_ok;

  // Simultaneous issue and completion on one requester cancel out.
  always_comb begin
    tot_nxt  = '0;
    all_zero = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_nxt[i] = cnt[i];
      if ((load && grant[i]) && !(r_last_hs && int'(r_idx) == i))
        cnt_nxt[i] = cnt[i] + CNT_W'(1);
      else if (!(load && grant[i]) && (r_last_hs && int'(r_idx) == i) && (cnt[i] != '0))
        cnt_nxt[i] = cnt[i] - CNT_W'(1);
      tot_nxt = tot_nxt + 8'(cnt_nxt[i]);
      if (cnt_nxt[i] != '0) all_zero = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      arvalid_q       <= 1'b0;
      ar_q            <= '0;
      ptr             <= '0;
      outstanding_tot <= '0;
      idle            <= 1'b1;
      rid_err         <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
    end else begin
      if (load) begin
        arvalid_q <= 1'b1;
        ar_q      <= ar_sel;
        ptr       <= (grant_idx == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_WIDTH'(1);
      end else if (bus.m_arready) begin
        arvalid_q <= 1'b0;
      end
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= cnt_nxt[i];
      outstanding_tot <= tot_nxt;
      idle            <= !arvalid_nxt && all_zero;
      if (bus.m_rvalid && !r_ok) rid_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_ar_rr_arbiter.sv
// Self-checking bench for axi_ar_rr_arbiter: AR order scoreboard plus directed R and reset cases.
module tb_axi_ar_rr_arbiter;
  import axi_arb_pkg::*;

  localparam int NUM_REQ      = 4;
  localparam int REQ_ID_WIDTH = 3;
  localparam int ADDR_WIDTH   = 64;
  localparam int DATA_WIDTH   = 1024;
  localparam int ARUSER_WIDTH = 8;
  localparam int IDX_WIDTH    = 2;
  localparam int ID_WIDTH     = 5;
  localparam int W            = ID_WIDTH + ADDR_WIDTH;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] outstanding_tot;
  logic       idle;
  logic       rid_err;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  int sent  [NUM_REQ];
  int exp_k [NUM_REQ];

  logic [NUM_REQ-1:0]      hs;
  logic [NUM_REQ-1:0]      snap_ready;
  logic [NUM_REQ-1:0]      snap_rvalid;
  logic                    snap_arvalid;
  logic                    snap_mrready;
  logic [ID_WIDTH-1:0]     snap_arid;
  logic [ADDR_WIDTH-1:0]   snap_araddr;
  logic [REQ_ID_WIDTH-1:0] snap_rid;
  logic [127:0]            snap_rdata;
  logic [DATA_WIDTH-1:0]   rdata_pat;

  axi_ar_rr_arbiter_if #(
    .NUM_REQ      (NUM_REQ),
    .REQ_ID_WIDTH (REQ_ID_WIDTH),
    .ADDR_WIDTH   (ADDR_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH),
    .ARUSER_WIDTH (ARUSER_WIDTH)
  ) bus ();

  axi_ar_rr_arbiter #(
    .NUM_REQ         (NUM_REQ),
    .REQ_ID_WIDTH    (REQ_ID_WIDTH),
    .ADDR_WIDTH      (ADDR_WIDTH),
    .DATA_WIDTH      (DATA_WIDTH),
    .ARUSER_WIDTH    (ARUSER_WIDTH),
    .MAX_OUTSTANDING (16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus),
    .outstanding_tot (outstanding_tot),
    .idle            (idle),
    .rid_err         (rid_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- stimulus model ----------------
  function automatic logic [63:0] addr_of(input int i, input int k);
    return 64'(i + 1) * 64'h1000_0000 + 64'(k) * 64'h80;
  endfunction

  function automatic logic [2:0] arid_of(input int i);
    return 3'(i + 5);
  endfunction

  task automatic drive_req(input int i, input logic v);
    bus.s_arvalid[i]                                   = v;
    bus.s_arid[i*REQ_ID_WIDTH +: REQ_ID_WIDTH]         = arid_of(i);
    bus.s_araddr[i*ADDR_WIDTH +: ADDR_WIDTH]           = addr_of(i, sent[i]);
    bus.s_arlen[i*8 +: 8]                              = 8'd3;
    bus.s_arsize[i*3 +: 3]                             = AXI_SIZE_128B;
    bus.s_arburst[i*2 +: 2]                            = AXI_BURST_INCR;
    bus.s_aruser[i*ARUSER_WIDTH +: ARUSER_WIDTH]       = 8'(8'h10 + i);
  endtask

  task automatic expect_ar(input int i);
    exp_q.push_back({IDX_WIDTH'(i), arid_of(i), addr_of(i, exp_k[i])});
    exp_k[i]++;
  endtask

  task automatic clear_model();
    exp_q.delete();
    for (int i = 0; i < NUM_REQ; i++) begin
      sent[i]  = 0;
      exp_k[i] = 0;
      drive_req(i, 1'b0);
    end
  endtask

  task automatic quiet_inputs();
    bus.m_arready = 1'b0;
    bus.m_rvalid  = 1'b0;
    bus.m_rid     = '0;
    bus.m_rdata   = '0;
    bus.m_rresp   = 2'b00;
    bus.m_rlast   = 1'b0;
    bus.s_rready  = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    quiet_inputs();
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // One clock: sample at the falling edge, then advance accepted requesters after the rise.
  task automatic step();
    @(negedge clk);
    snap_ready   = bus.s_arready;
    snap_arvalid = bus.m_arvalid;
    snap_arid    = bus.m_arid;
    snap_araddr  = bus.m_araddr;
    snap_rvalid  = bus.s_rvalid;
    snap_mrready = bus.m_rready;
    snap_rid     = bus.s_rid;
    snap_rdata   = bus.s_rdata[127:0];
    hs           = bus.s_arready & bus.s_arvalid;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++)
      if (hs[i]) begin
        sent[i]++;
        drive_req(i, bus.s_arvalid[i]);
      end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!reset && bus.m_arvalid && bus.m_arready) begin
      if (exp_q.size() == 0) check("ar_extra_beat", 128'(exp_q.size()), 128'd1);
      else check("ar_beat", 128'({bus.m_arid, bus.m_araddr}), 128'(exp_q.pop_front()));
    end
  end

  // ---------------- tests ----------------
  initial begin
    quiet_inputs();
    clear_model();
    do_reset();

    // reset state
    check("rst_m_arvalid", 128'(bus.m_arvalid), 128'd0);
    check("rst_s_arready", 128'(bus.s_arready), 128'd0);
    check("rst_idle", 128'(idle), 128'd1);
    check("rst_rid_err", 128'(rid_err), 128'd0);
    check("rst_tot", 128'(outstanding_tot), 128'd0);

    // 1: all four requesting, host always ready -> 0,1,2,3,0 back to back
    bus.m_arready = 1'b1;
    for (int c = 0; c < 5; c++) expect_ar(c % NUM_REQ);
    for (int i = 0; i < NUM_REQ; i++) drive_req(i, 1'b1);
    for (int c = 0; c < 5; c++) begin
      step();
      check("t1_ready", 128'(snap_ready), 128'(4'b0001 << (c % NUM_REQ)));
    end
    for (int i = 0; i < NUM_REQ; i++) drive_req(i, 1'b0);
    step();
    check("t1_ready_after", 128'(snap_ready), 128'd0);
    check("t1_tot", 128'(outstanding_tot), 128'd5);
    check("t1_idle", 128'(idle), 128'd0);
    check("t1_sb_empty", 128'(exp_q.size()), 128'd0);

    // 2: host stalls for 5 cycles -> AR held stable, no new grants
    do_reset();
    expect_ar(0);
    expect_ar(1);
    drive_req(0, 1'b1);
    drive_req(1, 1'b1);
    step();
    check("t2_first_ready", 128'(snap_ready), 128'b0001);
    repeat (5) begin
      step();
      check("t2_hold_ready", 128'(snap_ready), 128'd0);
      check("t2_hold_valid", 128'(snap_arvalid), 128'd1);
      check("t2_hold_arid", 128'(snap_arid), 128'({2'd0, arid_of(0)}));
      check("t2_hold_addr", 128'(snap_araddr), 128'(addr_of(0, 0)));
    end
    bus.m_arready = 1'b1;
    step();
    check("t2_release_ready", 128'(snap_ready), 128'b0010);
    drive_req(0, 1'b0);
    drive_req(1, 1'b0);
    step();
    check("t2_drain_ready", 128'(snap_ready), 128'd0);
    check("t2_tot", 128'(outstanding_tot), 128'd2);
    check("t2_sb_empty", 128'(exp_q.size()), 128'd0);

    // 3: outstanding limit on requester 0
    do_reset();
    bus.m_arready = 1'b1;
    drive_req(0, 1'b1);
    for (int k = 0; k < 16; k++) begin
      expect_ar(0);
      step();
      check("t3_ready", 128'(snap_ready), 128'b0001);
    end
    expect_ar(1);
    drive_req(1, 1'b1);
    step();
    check("t3_blocked_other", 128'(snap_ready), 128'b0010);
    drive_req(1, 1'b0);
    step();
    check("t3_blocked", 128'(snap_ready), 128'd0);
    check("t3_tot_full", 128'(outstanding_tot), 128'd17);
    bus.m_rvalid = 1'b1;
    bus.m_rlast  = 1'b1;
    bus.m_rid    = 5'b00_000;
    bus.s_rready = 4'b0001;
    step();
    check("t3_r_rvalid", 128'(snap_rvalid), 128'b0001);
    check("t3_r_mrready", 128'(snap_mrready), 128'd1);
    check("t3_r_still_blocked", 128'(snap_ready), 128'd0);
    bus.m_rvalid = 1'b0;
    bus.m_rlast  = 1'b0;
    bus.s_rready = '0;
    expect_ar(0);
    step();
    check("t3_reenable", 128'(snap_ready), 128'b0001);
    drive_req(0, 1'b0);
    step();
    check("t3_tot_end", 128'(outstanding_tot), 128'd17);
    check("t3_sb_empty", 128'(exp_q.size()), 128'd0);

    // 4: R routing for idx 2, rid 3, four beats with a stall first
    do_reset();
    bus.m_arready = 1'b1;
    expect_ar(2);
    drive_req(2, 1'b1);
    step();
    check("t4_ready", 128'(snap_ready), 128'b0100);
    check("t4_arlen", 128'(bus.m_arlen), 128'd3);
    check("t4_aruser", 128'(bus.m_aruser), 128'h12);
    drive_req(2, 1'b0);
    step();
    check("t4_tot_issued", 128'(outstanding_tot), 128'd1);
    bus.m_rid    = 5'b10_011;
    bus.m_rvalid = 1'b1;
    bus.s_rready = 4'b1011;
    step();
    check("t4_stall_rvalid", 128'(snap_rvalid), 128'b0100);
    check("t4_stall_mrready", 128'(snap_mrready), 128'd0);
    check("t4_rid", 128'(snap_rid), 128'd3);
    bus.s_rready = 4'b0100;
    for (int b = 0; b < 4; b++) begin
      for (int w = 0; w < DATA_WIDTH / 32; w++) rdata_pat[w*32 +: 32] = $urandom;
      bus.m_rdata = rdata_pat;
      bus.m_rresp = 2'(b);
      bus.m_rlast = (b == 3);
      step();
      check("t4_beat_rvalid", 128'(snap_rvalid), 128'b0100);
      check("t4_beat_mrready", 128'(snap_mrready), 128'd1);
      check("t4_beat_data", snap_rdata, rdata_pat[127:0]);
      if (b < 3) check("t4_tot_mid", 128'(outstanding_tot), 128'd1);
    end
    bus.m_rvalid = 1'b0;
    bus.m_rlast  = 1'b0;
    check("t4_tot_done", 128'(outstanding_tot), 128'd0);
    check("t4_idle", 128'(idle), 128'd1);
    check("t4_sb_empty", 128'(exp_q.size()), 128'd0);

    // 5: load and rlast on requester 1 in one cycle at count 4
    do_reset();
    bus.m_arready = 1'b1;
    drive_req(1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      expect_ar(1);
      step();
    end
    check("t5_tot_before", 128'(outstanding_tot), 128'd4);
    expect_ar(1);
    bus.m_rid    = 5'b01_000;
    bus.m_rvalid = 1'b1;
    bus.m_rlast  = 1'b1;
    bus.s_rready = 4'b0010;
    step();
    check("t5_ready", 128'(snap_ready), 128'b0010);
    check("t5_mrready", 128'(snap_mrready), 128'd1);
    drive_req(1, 1'b0);
    bus.m_rvalid = 1'b0;
    bus.m_rlast  = 1'b0;
    bus.s_rready = '0;
    check("t5_tot_same", 128'(outstanding_tot), 128'd4);
    step();
    check("t5_tot_after", 128'(outstanding_tot), 128'd4);
    check("t5_sb_empty", 128'(exp_q.size()), 128'd0);

    // 6: reset while an AR is held and counters are non-zero
    do_reset();
    bus.m_arready = 1'b1;
    expect_ar(2);
    drive_req(2, 1'b1);
    step();
    step();
    bus.m_arready = 1'b0;
    drive_req(2, 1'b0);
    step();
    check("t6_held", 128'(snap_arvalid), 128'd1);
    check("t6_tot_pre", 128'(outstanding_tot), 128'd2);
    check("t6_sb_pre", 128'(exp_q.size()), 128'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_model();
    check("t6_m_arvalid", 128'(bus.m_arvalid), 128'd0);
    check("t6_idle", 128'(idle), 128'd1);
    check("t6_tot", 128'(outstanding_tot), 128'd0);
    bus.m_arready = 1'b1;
    expect_ar(0);
    for (int i = 0; i < NUM_REQ; i++) drive_req(i, 1'b1);
    step();
    check("t6_ptr_zero", 128'(snap_ready), 128'b0001);
    for (int i = 0; i < NUM_REQ; i++) drive_req(i, 1'b0);
    step();
    check("t6_sb_empty", 128'(exp_q.size()), 128'd0);
    check("end_rid_err", 128'(rid_err), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
